slave_bus_receiver: RTL and testbench

//  Slave-side receiver for the I2C bus driven by the master SCL generator (100 kHz SCL).
//  It synchronises and deglitches SCL/SDA and detects START/STOP conditions.
//  It shifts in the address byte and compares it to SLAVE_ADDR, then receives data bytes.
//  It ACKs each matched byte by asserting an open-drain pull enable, for use with an external bufif SDA buffer.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_filter.sv | 42 ++++
 rtl/slave_bus_receiver.sv | 140 ++++++++++++++
 tb/tb_slave_bus_receiver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C slave receiver.
// Holds the receiver FSM state enum and bus field widths.
package i2c_pkg;

    localparam int I2C_ADDR_W    = 7;
    localparam int I2C_BYTE_W    = 8;
    localparam int I2C_BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one I2C bus line.
// Ports: fpga_clock, reset (async, high), line_in (raw), line_f (filtered).
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic fpga_clock,
    input  logic reset,
    input  logic line_in,
    output logic line_f
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       stable_cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // The counter tracks how many consecutive synced samples have
    // disagreed with the filtered value; the filter flips on the
    // FILTER_LEN-th such sample, so shorter glitches are swallowed.
    always_ff @(posedge fpga_clock or posedge reset) begin
        if (reset) begin
            sync       <= '1;
            stable_cnt <= '0;
            line_f     <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_in};
            if (synced == line_f) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
                line_f     <= synced;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/slave_bus_receiver.sv
// I2C slave write receiver: START/STOP detect, address match, byte RX, ACK.
// Ports: fpga_clock, reset, scl_in, sda_in -> sda_pull_en, rx_data, rx_valid,
//        addr_match, start_det, stop_det, busy.
module slave_bus_receiver
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILTER_LEN  = 3
) (
    input  logic                  fpga_clock,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_pull_en,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  addr_match,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  busy
);

    localparam logic [I2C_BIT_CNT_W-1:0] FULL = I2C_BIT_CNT_W'(I2C_BYTE_W);

    state_t                   state;
    logic [I2C_BIT_CNT_W-1:0] bit_cnt;
    logic [I2C_BYTE_W-1:0]    shift;
    logic                     scl_f, sda_f;
    logic                     scl_q, sda_q;
    logic                     scl_rise, scl_fall;
    logic                     start_cond, stop_cond;
    logic                     shifting;

    i2c_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_scl_filter (
        .fpga_clock(fpga_clock),
        .reset     (reset),
        .line_in   (scl_in),
        .line_f    (scl_f)
    );

    i2c_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_sda_filter (
        .fpga_clock(fpga_clock),
        .reset     (reset),
        .line_in   (sda_in),
        .line_f    (sda_f)
    );

    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;

    // Requiring SCL high in both this and the previous cycle makes an
    // SDA change coincident with an SCL edge count as data.
    assign start_cond = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_cond  = scl_f & scl_q & ~sda_q & sda_f;

    assign shifting = (state == ADDR || state == DATA)
                    && scl_rise && bit_cnt != FULL;

    assign busy = (state != IDLE);

    always_ff @(posedge fpga_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            sda_pull_en <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            addr_match  <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
        end else begin
            scl_q     <= scl_f;
            sda_q     <= sda_f;
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;

            if (shifting) begin
                shift   <= {shift[I2C_BYTE_W-2:0], sda_f};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (start_cond) begin
                state       <= ADDR;
                bit_cnt     <= '0;
                addr_match  <= 1'b0;
                sda_pull_en <= 1'b0;
                start_det   <= 1'b1;
            end else if (stop_cond) begin
                state       <= IDLE;
                addr_match  <= 1'b0;
                sda_pull_en <= 1'b0;
                stop_det    <= 1'b1;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_fall && bit_cnt == FULL) begin
                            // Reads are never served, so R/W=1 is NACKed.
                            if (shift[I2C_BYTE_W-1:1] == SLAVE_ADDR
                                && !shift[0]) begin
                                sda_pull_en <= 1'b1;
                                addr_match  <= 1'b1;
                                state       <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            sda_pull_en <= 1'b0;
                            bit_cnt     <= '0;
                            state       <= DATA;
                        end
                    end
                    DATA: begin
                        if (scl_fall && bit_cnt == FULL) begin
                            rx_data     <= shift;
                            rx_valid    <= 1'b1;
                            sda_pull_en <= 1'b1;
                            state       <= DATA_ACK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slave_bus_receiver.sv
// Self-checking bench for slave_bus_receiver.
// Drives an open-drain I2C bus model and checks ACK, data and event pulses.
module tb_slave_bus_receiver;
    import i2c_pkg::*;

    logic       fpga_clock = 1'b0;
    logic       reset      = 1'b1;
    logic       scl_m      = 1'b1;
    logic       sda_m      = 1'b1;
    logic       scl_in, sda_in;
    logic       sda_pull_en;
    logic [7:0] rx_data;
    logic       rx_valid, addr_match, start_det, stop_det, busy;

    // Wired-AND bus: master's SDA and the slave's pull-down.
    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_pull_en;

    slave_bus_receiver dut (
        .fpga_clock (fpga_clock),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_pull_en(sda_pull_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy)
    );

    always #10 fpga_clock = ~fpga_clock;

    int         checks  = 0;
    int         errors  = 0;
    int         n_valid = 0;
    int         n_start = 0;
    int         n_stop  = 0;
    int         n_pull  = 0;
    logic       pull_d  = 1'b0;
    logic [7:0] rxq[$];

    always @(negedge fpga_clock) begin
        if (rx_valid) begin
            n_valid++;
            rxq.push_back(rx_data);
        end
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
        if (sda_pull_en && !pull_d) n_pull++;
        pull_d = sda_pull_en;
    end

    typedef struct {
        logic [7:0] addr;
        logic       has_data;
        logic [7:0] data;
        logic       exp_ack_a;
        logic       exp_ack_d;
        int         exp_valid;
        int         exp_pulls;
        logic [7:0] exp_rx;
        logic       exp_match;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge fpga_clock);
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        cyc(125);
        scl_m = 1'b1;
        cyc(125);
        sda_m = 1'b0;
        cyc(125);
        scl_m = 1'b0;
        cyc(125);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        cyc(125);
        scl_m = 1'b1;
        cyc(125);
        sda_m = 1'b1;
        cyc(250);
    endtask

    task automatic send_bits(input logic [7:0] b, input int glitch_bit);
        for (int i = 7; i >= 0; i--) begin
            cyc(125);
            sda_m = b[i];
            cyc(125);
            scl_m = 1'b1;
            if (i == glitch_bit) begin
                cyc(100);
                scl_m = 1'b0;
                cyc(2);
                scl_m = 1'b1;
                cyc(148);
            end else begin
                cyc(250);
            end
            scl_m = 1'b0;
        end
    endtask

    // ACK counts only if the pull is held across the whole high phase.
    task automatic ack_clock(output logic acked);
        cyc(125);
        sda_m = 1'b1;
        cyc(125);
        scl_m = 1'b1;
        cyc(5);
        acked = sda_pull_en;
        cyc(240);
        acked = acked & sda_pull_en;
        cyc(5);
        acked = acked & sda_pull_en;
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit,
                             output logic acked);
        send_bits(b, glitch_bit);
        ack_clock(acked);
    endtask

    initial begin
        logic ack;
        int   v0, s0, p0, q0;

        vecs[0] = '{8'hA0, 1'b1, 8'hA5, 1'b1, 1'b1, 1, 2, 8'hA5, 1'b1};
        vecs[1] = '{8'hA2, 1'b1, 8'h55, 1'b0, 1'b0, 0, 0, 8'hA5, 1'b0};
        vecs[2] = '{8'hA1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 8'hA5, 1'b0};

        cyc(5);
        check("rst sda_pull_en", sda_pull_en, 0);
        check("rst rx_data", rx_data, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst addr_match", addr_match, 0);
        check("rst start_det", start_det, 0);
        check("rst stop_det", stop_det, 0);
        check("rst busy", busy, 0);
        reset = 1'b0;
        cyc(20);

        for (int k = 0; k < 3; k++) begin
            v0 = n_valid; s0 = n_start; p0 = n_stop; q0 = n_pull;
            do_start();
            check($sformatf("v%0d start_det", k), n_start - s0, 1);
            send_byte(vecs[k].addr, -1, ack);
            check($sformatf("v%0d addr ack", k), ack, vecs[k].exp_ack_a);
            if (vecs[k].has_data) begin
                send_byte(vecs[k].data, -1, ack);
                check($sformatf("v%0d data ack", k), ack, vecs[k].exp_ack_d);
            end
            check($sformatf("v%0d addr_match", k), addr_match,
                  vecs[k].exp_match);
            check($sformatf("v%0d busy", k), busy, 1);
            if (k == 2)
                check("v2 state", dut.state, WAIT_STOP);
            do_stop();
            check($sformatf("v%0d rx_valid cnt", k), n_valid - v0,
                  vecs[k].exp_valid);
            check($sformatf("v%0d rx_data", k), rx_data, vecs[k].exp_rx);
            check($sformatf("v%0d pull rises", k), n_pull - q0,
                  vecs[k].exp_pulls);
            check($sformatf("v%0d stop_det", k), n_stop - p0, 1);
            check($sformatf("v%0d busy after stop", k), busy, 0);
            check($sformatf("v%0d match after stop", k), addr_match, 0);
        end

        // Repeated START between two data bytes.
        rxq.delete();
        v0 = n_valid; s0 = n_start; p0 = n_stop;
        do_start();
        send_byte(8'hA0, -1, ack);
        check("rs addr1 ack", ack, 1);
        send_byte(8'h3C, -1, ack);
        check("rs data1 ack", ack, 1);
        do_start();
        check("rs match cleared", addr_match, 0);
        send_byte(8'hA0, -1, ack);
        check("rs addr2 ack", ack, 1);
        send_byte(8'hC3, -1, ack);
        check("rs data2 ack", ack, 1);
        check("rs no stop yet", n_stop - p0, 0);
        check("rs start count", n_start - s0, 2);
        do_stop();
        check("rs stop count", n_stop - p0, 1);
        check("rs valid count", n_valid - v0, 2);
        check("rs byte0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h3C);
        check("rs byte1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'hC3);

        // Short SCL low glitch inside a high phase.
        v0 = n_valid;
        do_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h69, 4, ack);
        check("gl data ack", ack, 1);
        do_stop();
        check("gl valid count", n_valid - v0, 1);
        check("gl rx_data", rx_data, 8'h69);

        // Asynchronous reset during the data ACK phase.
        do_start();
        send_byte(8'hA0, -1, ack);
        send_bits(8'h5A, -1);
        cyc(20);
        check("ar pull before", sda_pull_en, 1);
        #3 reset = 1'b1;
        #1;
        check("ar pull async", sda_pull_en, 0);
        check("ar busy async", busy, 0);
        cyc(3);
        sda_m = 1'b1;
        scl_m = 1'b1;
        cyc(10);
        reset = 1'b0;
        cyc(20);
        check("ar rx_data reset", rx_data, 0);
        v0 = n_valid; s0 = n_start;
        do_start();
        send_byte(8'hA0, -1, ack);
        check("ar addr ack", ack, 1);
        send_byte(8'h96, -1, ack);
        check("ar data ack", ack, 1);
        do_stop();
        check("ar valid count", n_valid - v0, 1);
        check("ar rx_data", rx_data, 8'h96);
        check("ar start count", n_start - s0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
